// File: rtl/operand_bypass_unit.sv
// ID->EX operand bypass and hazard unit.
// Tracks the destination tags of instructions in the EX, MEM and WB slots.
// For every source operand it forwards the youngest matching producer.
// It stalls issue while that producer has no result yet (load-use).
// A watchdog sets a sticky flag when a stall lasts too long.
module operand_bypass_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int STALL_MAX  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]     id_src_data,
  input  logic [REG_ADDR_W-1:0]         id_dst_addr,
  input  logic                          id_wr_en,
  input  logic [DATA_W-1:0]             ex_result,
  input  logic                          ex_res_vld,
  input  logic [DATA_W-1:0]             mem_result,
  input  logic                          mem_res_vld,
  input  logic [DATA_W-1:0]             wb_result,
  output logic                          stall,
  output logic                          ex_valid,
  output logic [NUM_SRC*DATA_W-1:0]     ex_opnd,
  output logic [NUM_SRC*2-1:0]          ex_fwd_sel,
  output logic                          err_stall_timeout
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_EX  = 2'b11;

  // Counter holds the number of consecutive stall cycles already completed.
  // It saturates at STALL_MAX.
  localparam int CNT_W = $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STALL_MAX);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Tag slots: a slot is valid only when its instruction writes a non-zero register.
  logic                  ex_vld_q,  mem_vld_q,  wb_vld_q;
  logic [REG_ADDR_W-1:0] ex_dst_q,  mem_dst_q,  wb_dst_q;

  logic [NUM_SRC-1:0]        hazard;
  logic [NUM_SRC*DATA_W-1:0] sel_data;
  logic [NUM_SRC*2-1:0]      sel_code;
  logic                      stall_int;
  logic                      issue;
  logic                      dst_wr;

  logic                      ex_valid_q;
  logic [NUM_SRC*DATA_W-1:0] opnd_q;
  logic [NUM_SRC*2-1:0]      fwd_sel_q;

  state_t           state_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             err_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_ADDR_W-1:0] src;
      logic                  hit_ex, hit_mem, hit_wb;
      logic [DATA_W-1:0]     data_d;
      logic [1:0]            code_d;
      logic                  haz_d;

      assign src     = id_src_addr[gi*REG_ADDR_W +: REG_ADDR_W];
      assign hit_ex  = ex_vld_q  && (ex_dst_q  == src);
      assign hit_mem = mem_vld_q && (mem_dst_q == src);
      assign hit_wb  = wb_vld_q  && (wb_dst_q  == src);

      // Youngest matching producer wins; a producer without its result yet is a hazard.
      always_comb begin
        data_d = id_src_data[gi*DATA_W +: DATA_W];
        code_d = SEL_RF;
        haz_d  = 1'b0;
        if (hit_ex) begin
          data_d = ex_result;
          code_d = SEL_EX;
          haz_d  = !ex_res_vld;
        end else if (hit_mem) begin
          data_d = mem_result;
          code_d = SEL_MEM;
          haz_d  = !mem_res_vld;
        end else if (hit_wb) begin
          data_d = wb_result;
          code_d = SEL_WB;
        end
      end

      assign sel_data[gi*DATA_W +: DATA_W] = data_d;
      assign sel_code[gi*2 +: 2]           = code_d;
      assign hazard[gi]                    = haz_d;

      assign ex_opnd[gi*DATA_W +: DATA_W]  = opnd_q[gi*DATA_W +: DATA_W];
      assign ex_fwd_sel[gi*2 +: 2]         = fwd_sel_q[gi*2 +: 2];
    end
  endgenerate

  // Flush overrides stall so that a killed instruction never holds the front end.
  assign stall_int = id_valid && (|hazard) && !flush;
  assign issue     = id_valid && !stall_int && !flush;
  assign dst_wr    = id_wr_en && (id_dst_addr != '0);

  assign stall             = stall_int;
  assign ex_valid          = ex_valid_q;
  assign err_stall_timeout = err_q;

  // Advance the tag pipeline each cycle; EX receives a bubble unless an instruction issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld_q  <= 1'b0;
      ex_dst_q  <= '0;
      mem_vld_q <= 1'b0;
      mem_dst_q <= '0;
      wb_vld_q  <= 1'b0;
      wb_dst_q  <= '0;
    end else begin
      wb_vld_q  <= mem_vld_q;
      wb_dst_q  <= mem_dst_q;
      mem_vld_q <= ex_vld_q;
      mem_dst_q <= ex_dst_q;
      ex_vld_q  <= issue && dst_wr;
      ex_dst_q  <= issue ? id_dst_addr : '0;
    end
  end

  // Register the selected operands into EX on issue; otherwise hold the last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      opnd_q     <= '0;
      fwd_sel_q  <= '0;
    end else begin
      ex_valid_q <= issue;
      if (issue) begin
        opnd_q    <= sel_data;
        fwd_sel_q <= sel_code;
      end
    end
  end

  // RUN/STALL tracker with a sticky timeout once a stall reaches STALL_MAX consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          stall_cnt_q <= '0;
          if (stall_int) begin
            state_q     <= ST_STALL;
            stall_cnt_q <= CNT_ONE;
            if (CNT_LAST == '0) err_q <= 1'b1;
          end
        end
        ST_STALL: begin
          if (stall_int) begin
            if (stall_cnt_q != CNT_SAT) stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (stall_cnt_q >= CNT_LAST) err_q <= 1'b1;
          end else begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          stall_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Bench for operand_bypass_unit: directed scenarios plus randomized traffic,
// all checked against a slot-list reference model kept in this file.
module tb_operand_bypass_unit;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NS   = 2;
  // Slots always advance, so a load-use stall lasts at most two cycles.
  // A small limit lets the watchdog actually fire.
  localparam int SMAX = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          id_valid = 1'b0;
  logic [NS*AW-1:0] id_src_addr = '0;
  logic [NS*DW-1:0] id_src_data = '0;
  logic [AW-1:0] id_dst_addr = '0;
  logic          id_wr_en = 1'b0;
  logic [DW-1:0] ex_result = '0;
  logic          ex_res_vld = 1'b0;
  logic [DW-1:0] mem_result = '0;
  logic          mem_res_vld = 1'b0;
  logic [DW-1:0] wb_result = '0;
  logic          stall;
  logic          ex_valid;
  logic [NS*DW-1:0] ex_opnd;
  logic [NS*2-1:0]  ex_fwd_sel;
  logic          err_stall_timeout;

  always #5 clk = ~clk;

  operand_bypass_unit #(
    .DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .STALL_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_src_data(id_src_data),
    .id_dst_addr(id_dst_addr), .id_wr_en(id_wr_en),
    .ex_result(ex_result), .ex_res_vld(ex_res_vld),
    .mem_result(mem_result), .mem_res_vld(mem_res_vld),
    .wb_result(wb_result), .stall(stall), .ex_valid(ex_valid),
    .ex_opnd(ex_opnd), .ex_fwd_sel(ex_fwd_sel),
    .err_stall_timeout(err_stall_timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: list of in-flight writers, index 0 = youngest (EX).
  bit            m_vld[3];
  int            m_dst[3];
  bit            m_ex_valid;
  logic [DW-1:0] m_opnd[NS];
  int            m_sel[NS];
  bit            m_err;
  int            m_run;
  bit            m_stall;
  logic [DW-1:0] c_data[NS];
  int            c_sel[NS];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_vld[k] = 0;
      m_dst[k] = 0;
    end
    for (int i = 0; i < NS; i++) begin
      m_opnd[i] = '0;
      m_sel[i]  = 0;
    end
    m_ex_valid = 0;
    m_err      = 0;
    m_run      = 0;
  endfunction

  function automatic void model_eval();
    bit haz = 0;
    for (int i = 0; i < NS; i++) begin
      int src = int'(id_src_addr[i*AW +: AW]);
      c_sel[i]  = 0;
      c_data[i] = id_src_data[i*DW +: DW];
      for (int k = 0; k < 3; k++) begin
        if (m_vld[k] && m_dst[k] == src) begin
          c_sel[i]  = 3 - k;
          c_data[i] = (k == 0) ? ex_result : (k == 1) ? mem_result : wb_result;
          if ((k == 0 && !ex_res_vld) || (k == 1 && !mem_res_vld)) haz = 1;
          break;
        end
      end
    end
    m_stall = id_valid && haz && !flush;
  endfunction

  function automatic void model_step();
    bit issue = id_valid && !m_stall && !flush;
    m_vld[2] = m_vld[1]; m_dst[2] = m_dst[1];
    m_vld[1] = m_vld[0]; m_dst[1] = m_dst[0];
    m_vld[0] = issue && id_wr_en && (id_dst_addr != 0);
    m_dst[0] = int'(id_dst_addr);
    m_ex_valid = issue;
    if (issue) begin
      for (int i = 0; i < NS; i++) begin
        m_opnd[i] = c_data[i];
        m_sel[i]  = c_sel[i];
      end
    end
    if (m_stall) m_run++;
    else m_run = 0;
    if (m_run >= SMAX) m_err = 1;
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, " ex_valid"}, 64'(ex_valid), 64'(m_ex_valid));
    check_val({tag, " err"}, 64'(err_stall_timeout), 64'(m_err));
    for (int i = 0; i < NS; i++) begin
      check_val($sformatf("%s opnd%0d", tag, i), 64'(ex_opnd[i*DW +: DW]), 64'(m_opnd[i]));
      check_val($sformatf("%s sel%0d", tag, i), 64'(ex_fwd_sel[i*2 +: 2]), 64'(m_sel[i]));
    end
  endtask

  task automatic drive_id(input bit v, input int s0, input int s1, input logic [DW-1:0] d0,
                          input logic [DW-1:0] d1, input int dst, input bit wr);
    id_valid    = v;
    id_src_addr = {AW'(s1), AW'(s0)};
    id_src_data = {d1, d0};
    id_dst_addr = AW'(dst);
    id_wr_en    = wr;
  endtask

  // One clock: check combinational stall before the edge, registered outputs after it.
  task automatic step(input string tag);
    #1;
    model_eval();
    check_val({tag, " stall"}, 64'(stall), 64'(m_stall));
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
    $display("[%0t] %s valid=%0b stall=%0b ex_valid=%0b opnd=%h sel=%b err=%0b",
             $time, tag, id_valid, m_stall, ex_valid, ex_opnd, ex_fwd_sel, err_stall_timeout);
  endtask

  // Asynchronous reset pulse asserted between clock edges.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val({tag, " stall"}, 64'(stall), 64'd0);
    check_outputs(tag);
    $display("[%0t] %s async reset", $time, tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs("reset");
    check_val("reset stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // No dependencies: add r3 <- r1, r2.
    ex_res_vld = 1; mem_res_vld = 1;
    drive_id(1, 1, 2, 32'd5, 32'd7, 3, 1);
    step("nodep");
    check_val("nodep opnd_const", 64'(ex_opnd), {32'd7, 32'd5});
    check_val("nodep sel_const", 64'(ex_fwd_sel), 64'd0);

    // EX forwarding of r3.
    ex_result = 32'h10;
    drive_id(1, 3, 0, 32'h0, 32'h0, 6, 1);
    step("exfwd");
    check_val("exfwd opnd_const", 64'(ex_opnd[DW-1:0]), 64'h10);
    check_val("exfwd sel_const", 64'(ex_fwd_sel[1:0]), 64'd3);

    // r3 again: now EX=r3, MEM=r6, WB=r3.
    drive_id(1, 0, 0, 32'h0, 32'h0, 3, 1);
    step("exwb_setup");
    ex_result = 32'h22; wb_result = 32'h99;
    drive_id(1, 3, 3, 32'h1, 32'h2, 9, 1);
    step("exwb");
    check_val("exwb opnd_const", 64'(ex_opnd), {32'h22, 32'h22});
    check_val("exwb sel_const", 64'(ex_fwd_sel), 64'b1111);

    // Load-use: lw r4 then consumer of r4.
    drive_id(1, 0, 0, 32'h0, 32'h0, 4, 1);
    step("lw");
    ex_res_vld = 0;
    drive_id(1, 4, 1, 32'h0, 32'h3, 8, 1);
    step("lu_stall");
    check_val("lu bubble", 64'(ex_valid), 64'd0);
    ex_res_vld = 1; mem_res_vld = 1; mem_result = 32'hAB;
    step("lu_memfwd");
    check_val("lu opnd_const", 64'(ex_opnd[DW-1:0]), 64'hAB);
    check_val("lu sel_const", 64'(ex_fwd_sel[1:0]), 64'd2);

    // r0 never forwards.
    drive_id(1, 0, 0, 32'h0, 32'h0, 0, 1);
    step("r0_prod");
    ex_res_vld = 0;
    drive_id(1, 0, 0, 32'h0, 32'h0, 5, 1);
    step("r0_use");
    check_val("r0 sel_const", 64'(ex_fwd_sel), 64'd0);

    // Watchdog: load in EX then in MEM with no data gives two stall cycles.
    ex_res_vld = 1; mem_res_vld = 1;
    drive_id(1, 0, 0, 32'h0, 32'h0, 4, 1);
    step("to_lw");
    ex_res_vld = 0; mem_res_vld = 0;
    drive_id(1, 4, 4, 32'h0, 32'h0, 7, 1);
    step("to_stall1");
    check_val("to err_after1", 64'(err_stall_timeout), 64'd0);
    step("to_stall2");
    check_val("to err_after2", 64'(err_stall_timeout), 64'd1);
    ex_res_vld = 1;
    step("to_release");
    check_val("to sticky", 64'(err_stall_timeout), 64'd1);

    // Flush during a load-use stall.
    mem_res_vld = 1;
    drive_id(1, 0, 0, 32'h0, 32'h0, 4, 1);
    step("fl_lw");
    ex_res_vld = 0; flush = 1;
    drive_id(1, 4, 0, 32'h0, 32'h0, 7, 1);
    step("fl_stall");
    check_val("fl ex_valid", 64'(ex_valid), 64'd0);
    flush = 0; ex_res_vld = 1;

    // Reset mid-stall.
    drive_id(1, 0, 0, 32'h0, 32'h0, 4, 1);
    step("rs_lw");
    ex_res_vld = 0;
    drive_id(1, 4, 0, 32'h0, 32'h0, 7, 1);
    #1;
    model_eval();
    check_val("rs pre_stall", 64'(stall), 64'd1);
    async_reset("rs_mid");

    // Randomized traffic over a small register window.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end
      drive_id(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $urandom, $urandom, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      ex_result   = $urandom;
      mem_result  = $urandom;
      wb_result   = $urandom;
      ex_res_vld  = bit'($urandom_range(0, 2) != 0);
      mem_res_vld = bit'($urandom_range(0, 2) != 0);
      flush       = bit'($urandom_range(0, 9) == 0);
      step($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
